// File: rtl/multi_digit_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_digit_timer_pkg
// Brief    : Shared state encoding and hex-to-7-segment table for the
//            multi-digit event timer.
// Revision : 1.0 - initial release
// ============================================================================
package multi_digit_timer_pkg;

  // Timer FSM state encoding (3-bit, exported on the state port)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_COUNT = 3'b001,
    ST_HOLD  = 3'b010,
    ST_BUZZ  = 3'b011,
    ST_WRAP  = 3'b100
  } state_e;

  // Segment patterns {g,f,e,d,c,b,a}, active-high; entry 15 first
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  localparam logic [6:0] SEG_ZERO = 7'b0111111;

  // Table lookup for a single hex nibble
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage : multi_digit_timer_pkg
`default_nettype wire

// File: rtl/multi_digit_timer_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Brief    : Multiplexed 7-segment driver. Holds each digit for SCAN_DIV
//            cycles, rotates the one-hot select, picks the matching counter
//            nibble and decodes it. Select and segments are registered
//            together so they always change in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan
  import multi_digit_timer_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNT_W-1:0]      count,
  output logic [6:0]            seg_display,
  output logic [NUM_DIGITS-1:0] digit_select
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] dsel_q;

  logic [31:0]           w_padded;
  logic [4:0]            w_bitpos;
  logic [3:0]            w_nibble;

  // Scan divider and digit rotation
  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Nibble for the upcoming digit; digits beyond the counter width read zero
  always_comb begin
    w_padded = 32'(count);
    w_bitpos = {3'(idx_d), 2'b00};
    w_nibble = w_padded[w_bitpos +: 4];
  end

  // Registered scan state, digit select and segment pattern
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      idx_q  <= '0;
      seg_q  <= SEG_ZERO;
      dsel_q <= NUM_DIGITS'(1);
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      seg_q  <= seg_decode(w_nibble);
      dsel_q <= NUM_DIGITS'(1) << idx_d;
    end
  end

  assign seg_display  = seg_q;
  assign digit_select = dsel_q;

endmodule : seg7_scan
`default_nettype wire

// File: rtl/multi_digit_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_digit_timer
// Brief    : Event counter with terminal-count buzzer, LED bank and a
//            multiplexed hex 7-segment display.
//            Build option MULTI_DIGIT_TIMER_BUZZ_PWM_EN: buzzer is a square
//            wave (1,1,0,0,...) during BUZZ instead of a steady 1.
// Revision : 1.0 - initial release
// ============================================================================
module multi_digit_timer
  import multi_digit_timer_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 4,
  parameter int LED_W       = 8,
  parameter int BUZZ_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      limit,
  input  logic                  led_mode,
  output logic [6:0]            seg_display,
  output logic [NUM_DIGITS-1:0] digit_select,
  output logic [LED_W-1:0]      leds,
  output logic                  buzzer,
  output logic [2:0]            state,
  output logic [CNT_W-1:0]      counter
);

  // At least two bits so the PWM phase bit always exists
  localparam int BW = ($clog2(BUZZ_CYCLES) < 2) ? 2 : $clog2(BUZZ_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [BW-1:0]    buzz_cnt_q, buzz_cnt_d;
  logic             w_buzz_done;

  logic [LED_W-1:0] leds_q, leds_d;
  logic             buzzer_q, buzzer_d;
  logic [LED_W-1:0] w_led_bin, w_led_walk;
  logic [31:0]      w_led_bit;

  assign w_buzz_done = (buzz_cnt_q == BW'(BUZZ_CYCLES - 1));

  // State, counter and BUZZ timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      counter_q  <= '0;
      buzz_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      buzz_cnt_q <= buzz_cnt_d;
    end
  end

  // Next-state, counter and BUZZ timer logic
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    case (state_q)
      ST_IDLE: begin
        counter_d = '0;
        if (enable) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        // Terminal count wins over a dropped enable
        if (counter_q == limit) begin
          state_d = ST_BUZZ;
        end else if (enable) begin
          counter_d = counter_q + 1'b1;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (enable) state_d = ST_COUNT;
      end
      ST_BUZZ: begin
        // Counter is cleared on the way out so WRAP already shows zero
        if (w_buzz_done) begin
          state_d   = ST_WRAP;
          counter_d = '0;
        end
      end
      ST_WRAP: begin
        counter_d = '0;
        state_d   = enable ? ST_COUNT : ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        counter_d = '0;
      end
    endcase

    // Timer restarts at zero on every BUZZ entry
    buzz_cnt_d = '0;
    if (state_d == ST_BUZZ && state_q == ST_BUZZ) begin
      buzz_cnt_d = buzz_cnt_q + 1'b1;
    end
  end

  // LED and buzzer values computed from next state so they align with it
  always_comb begin
    w_led_bin  = LED_W'(counter_d);
    w_led_bit  = 32'(counter_d) % LED_W;
    w_led_walk = LED_W'(1) << w_led_bit;

    leds_d   = '0;
    buzzer_d = 1'b0;
    if (state_d != ST_IDLE) begin
      leds_d = led_mode ? w_led_walk : w_led_bin;
    end
    if (state_d == ST_BUZZ) begin
`ifdef MULTI_DIGIT_TIMER_BUZZ_PWM_EN
      buzzer_d = ~buzz_cnt_d[1];
`else
      buzzer_d = 1'b1;
`endif
    end
  end

  // Registered LED bank and buzzer
  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q   <= '0;
      buzzer_q <= 1'b0;
    end else begin
      leds_q   <= leds_d;
      buzzer_q <= buzzer_d;
    end
  end

  seg7_scan #(
    .CNT_W      (CNT_W),
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan (
    .clk          (clk),
    .reset        (reset),
    .count        (counter_q),
    .seg_display  (seg_display),
    .digit_select (digit_select)
  );

  assign state   = state_q;
  assign counter = counter_q;
  assign leds    = leds_q;
  assign buzzer  = buzzer_q;

endmodule : multi_digit_timer
`default_nettype wire

// File: tb/tb_multi_digit_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_digit_timer
// Brief    : Directed self-checking bench for multi_digit_timer (defaults:
//            CNT_W=8, NUM_DIGITS=4, SCAN_DIV=4, LED_W=8, BUZZ_CYCLES=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_digit_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] limit;
  logic       led_mode;
  logic [6:0] seg_display;
  logic [3:0] digit_select;
  logic [7:0] leds;
  logic       buzzer;
  logic [2:0] state;
  logic [7:0] counter;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_digit_timer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .limit        (limit),
    .led_mode     (led_mode),
    .seg_display  (seg_display),
    .digit_select (digit_select),
    .leds         (leds),
    .buzzer       (buzzer),
    .state        (state),
    .counter      (counter)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_counter(input logic [7:0] v, input int budget);
    int n = 0;
    while (counter !== v && n < budget) begin
      tick();
      n++;
    end
    check_val("wait_counter", 32'(counter), 32'(v));
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    check_val("wait_state", 32'(state), 32'(s));
  endtask

  function automatic logic exp_buzz(input int i);
`ifdef MULTI_DIGIT_TIMER_BUZZ_PWM_EN
    return ((i / 2) % 2) == 0;
`else
    return (i >= 0);
`endif
  endfunction

  function automatic logic [6:0] exp_seg_a7(input int d);
    case (d)
      0:       return 7'b0000111;
      1:       return 7'b1110111;
      default: return 7'b0111111;
    endcase
  endfunction

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    limit    = 8'd5;
    led_mode = 1'b0;
    tick();
    tick();

    // Reset state
    check_val("rst_state",  32'(state),        32'h0);
    check_val("rst_cnt",    32'(counter),      32'h0);
    check_val("rst_leds",   32'(leds),         32'h0);
    check_val("rst_buzz",   32'(buzzer),       32'h0);
    check_val("rst_dsel",   32'(digit_select), 32'h1);
    check_val("rst_seg",    32'(seg_display),  32'h3F);

    // Count 0..5, buzz 16 cycles, wrap, count again
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    check_val("cnt_state0", 32'(state),   32'h1);
    check_val("cnt_val0",   32'(counter), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_val("cnt_state", 32'(state),   32'h1);
      check_val("cnt_val",   32'(counter), 32'(i));
      check_val("cnt_leds",  32'(leds),    32'(i));
    end
    tick();
    for (int i = 0; i < 16; i++) begin
      check_val("buzz_state", 32'(state),   32'h3);
      check_val("buzz_cnt",   32'(counter), 32'h5);
      check_val("buzz_out",   32'(buzzer),  32'(exp_buzz(i)));
      tick();
    end
    check_val("wrap_state", 32'(state),   32'h4);
    check_val("wrap_cnt",   32'(counter), 32'h0);
    check_val("wrap_buzz",  32'(buzzer),  32'h0);
    tick();
    check_val("recount_state", 32'(state),   32'h1);
    check_val("recount_cnt",   32'(counter), 32'h0);

    // Drop enable at 3, hold, resume at 4
    wait_counter(8'd3, 10);
    enable = 1'b0;
    tick();
    check_val("hold_state", 32'(state),   32'h2);
    check_val("hold_cnt",   32'(counter), 32'h3);
    tick();
    check_val("hold_cnt2",  32'(counter), 32'h3);
    enable = 1'b1;
    tick();
    check_val("resume_state", 32'(state),   32'h1);
    check_val("resume_cnt",   32'(counter), 32'h3);
    tick();
    check_val("resume_cnt4",  32'(counter), 32'h4);

    // Reset in the middle of BUZZ
    wait_state(3'h3, 10);
    for (int i = 0; i < 7; i++) tick();
    check_val("midbuzz_state", 32'(state),  32'h3);
    check_val("midbuzz_buzz",  32'(buzzer), 32'(exp_buzz(7)));
    reset = 1'b1;
    tick();
    check_val("buzzrst_state", 32'(state),        32'h0);
    check_val("buzzrst_buzz",  32'(buzzer),       32'h0);
    check_val("buzzrst_cnt",   32'(counter),      32'h0);
    check_val("buzzrst_dsel",  32'(digit_select), 32'h1);
    reset  = 1'b0;
    enable = 1'b0;

    // Freeze counter at A7 and watch the display scan
    limit  = 8'hFF;
    enable = 1'b1;
    tick();
    wait_counter(8'hA7, 200);
    enable = 1'b0;
    tick();
    check_val("a7_state", 32'(state),   32'h2);
    check_val("a7_cnt",   32'(counter), 32'hA7);
    check_val("a7_leds",  32'(leds),    32'hA7);
    begin
      logic [3:0] prev;
      logic       found;
      prev  = digit_select;
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
        tick();
        if (prev != 4'b0001 && digit_select == 4'b0001) found = 1'b1;
        prev = digit_select;
      end
      check_val("scan_sync", 32'(found), 32'h1);
    end
    for (int i = 0; i < 16; i++) begin
      check_val("scan_dsel", 32'(digit_select), 32'(4'b0001 << (i / 4)));
      check_val("scan_seg",  32'(seg_display),  32'(exp_seg_a7(i / 4)));
      tick();
    end

    // Walking-one LEDs at counter 10
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    led_mode = 1'b1;
    enable   = 1'b1;
    tick();
    check_val("walk_leds0", 32'(leds), 32'h01);
    wait_counter(8'd10, 20);
    enable = 1'b0;
    tick();
    check_val("walk_state", 32'(state), 32'h2);
    check_val("walk_leds",  32'(leds),  32'h04);

    // limit 0: BUZZ right after COUNT entry, then WRAP into IDLE
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    led_mode = 1'b0;
    limit    = 8'd0;
    enable   = 1'b1;
    tick();
    check_val("lim0_count", 32'(state), 32'h1);
    tick();
    check_val("lim0_buzz",  32'(state),   32'h3);
    check_val("lim0_cnt",   32'(counter), 32'h0);
    enable = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check_val("lim0_wrap",  32'(state), 32'h4);
    tick();
    check_val("lim0_idle",  32'(state),  32'h0);
    check_val("lim0_leds",  32'(leds),   32'h0);
    check_val("lim0_bz",    32'(buzzer), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_multi_digit_timer
`default_nettype wire
